// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the elastic pipeline stages.
// Purpose: default data/register widths, the stage payload record reused by
//          the IF/ID, ID/EX, EX/MEM and MEM/WB elastic stages, and a helper
//          that gives the flattened payload width for any WORD/RAW pair.
// Ports:   none (package).
package mem_wb_stage_pkg;

  localparam int WORD_DEF = 32;
  localparam int RAW_DEF  = 5;

  // Stage payload record at default widths. The field order matches the
  // flattened vector the stages build: wb, mem_r, terminate, mem, alu, dest.
  typedef struct packed {
    logic                wb;
    logic                mem_r;
    logic                terminate;
    logic [WORD_DEF-1:0] mem_result;
    logic [WORD_DEF-1:0] alu_result;
    logic [RAW_DEF-1:0]  reg_dest;
  } stage_payload_t;

  // Three control bits, two result words and one register address.
  function automatic int payload_w(input int word_w, input int raw_w);
    return 3 + 2 * word_w + raw_w;
  endfunction

endpackage

// File: rtl/mem_wb_stage_skid_slot.sv
// skid_slot: one valid bit plus one payload register.
// Purpose: storage element used twice by mem_wb_stage (head and skid).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   zero_i     drop valid and zero the payload (flush)
//   load_i     capture d_i and set valid
//   clear_i    drop valid, keep payload bits
//   d_i        payload to load
//   valid_o    slot holds an entry
//   q_o        stored payload
// Control priority: rst > zero_i > load_i > clear_i > hold.
module skid_slot
  import mem_wb_stage_pkg::*;
#(
  parameter int PW = payload_w(WORD_DEF, RAW_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          zero_i,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic [PW-1:0] d_i,
  output logic          valid_o,
  output logic [PW-1:0] q_o
);

  logic          valid_q;
  logic          valid_d;
  logic [PW-1:0] pl_q;
  logic [PW-1:0] pl_d;

  // Next-state selection for the valid bit and payload.
  always_comb begin
    valid_d = valid_q;
    pl_d    = pl_q;
    if (zero_i) begin
      valid_d = 1'b0;
      pl_d    = {PW{1'b0}};
    end else if (load_i) begin
      valid_d = 1'b1;
      pl_d    = d_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
      pl_d    = pl_q;
    end
  end

  // Slot state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pl_q    <= {PW{1'b0}};
    end else begin
      valid_q <= valid_d;
      pl_q    <= pl_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = pl_q;

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: elastic MEM->WB pipeline stage.
// Purpose: valid/ready register slice with a one-entry skid buffer, flush,
//          writeback-data selection, forwarding tap, halt on retirement of a
//          terminate entry, and a retired-instruction counter.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush                         discard both buffered entries
//   in_valid / in_ready           producer handshake
//   wb_in, mem_r_in, terminate_in, mem_result_in, alu_result_in, reg_dest_in
//                                 offered entry
//   out_valid / out_ready         writeback handshake (head entry)
//   wb_out, mem_r_out, terminate_out, wb_data_out, reg_dest_out
//                                 head entry fields
//   fwd_valid, fwd_dest, fwd_data forwarding tap (head only)
//   halted                        sticky halt after a terminate retires
//   retired_count                 retired entries, wraps
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int WORD  = WORD_DEF,
  parameter int RAW   = RAW_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             wb_in,
  input  logic             mem_r_in,
  input  logic             terminate_in,
  input  logic [WORD-1:0]  mem_result_in,
  input  logic [WORD-1:0]  alu_result_in,
  input  logic [RAW-1:0]   reg_dest_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wb_out,
  output logic             mem_r_out,
  output logic             terminate_out,
  output logic [WORD-1:0]  wb_data_out,
  output logic [RAW-1:0]   reg_dest_out,
  output logic             fwd_valid,
  output logic [RAW-1:0]   fwd_dest,
  output logic [WORD-1:0]  fwd_data,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  localparam int PW = payload_w(WORD, RAW);

  // Flattened payload layout, MSB first: wb, mem_r, terminate, mem, alu, dest.
  localparam int DEST_LO = 0;
  localparam int ALU_LO  = RAW;
  localparam int MEM_LO  = RAW + WORD;
  localparam int TERM_B  = PW - 3;
  localparam int MEMR_B  = PW - 2;
  localparam int WB_B    = PW - 1;

  logic [PW-1:0]    in_pl_s;
  logic [PW-1:0]    head_pl_s;
  logic [PW-1:0]    skid_pl_s;
  logic [PW-1:0]    head_d_s;
  logic             head_valid_s;
  logic             skid_valid_s;
  logic             accept_s;
  logic             retire_s;
  logic             head_load_s;
  logic             head_from_skid_s;
  logic             head_clear_s;
  logic             skid_load_s;
  logic             skid_clear_s;
  logic             halted_q;
  logic             halted_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [WORD-1:0]  mem_res_s;
  logic [WORD-1:0]  alu_res_s;

  assign in_pl_s = {wb_in, mem_r_in, terminate_in,
                    mem_result_in, alu_result_in, reg_dest_in};

  // in_ready depends on registers only, never on out_ready.
  assign in_ready = !skid_valid_s && !halted_q;
  // Flush suppresses both handshakes in its cycle.
  assign accept_s = in_valid && in_ready && !flush;
  assign retire_s = head_valid_s && out_ready && !flush;

  // Slot control decode: which slot loads, from where, and which slot empties.
  always_comb begin
    head_load_s      = 1'b0;
    head_from_skid_s = 1'b0;
    head_clear_s     = 1'b0;
    skid_load_s      = 1'b0;
    skid_clear_s     = 1'b0;
    if (flush) begin
      head_load_s = 1'b0;
    end else if (!head_valid_s) begin
      head_load_s = accept_s;
    end else if (retire_s) begin
      if (skid_valid_s) begin
        head_load_s      = 1'b1;
        head_from_skid_s = 1'b1;
        skid_clear_s     = 1'b1;
      end else if (accept_s) begin
        head_load_s = 1'b1;
      end else begin
        head_clear_s = 1'b1;
      end
    end else begin
      skid_load_s = accept_s;
    end
  end

  assign head_d_s = head_from_skid_s ? skid_pl_s : in_pl_s;

  skid_slot #(.PW(PW)) u_head (
    .clk     (clk),
    .rst     (rst),
    .zero_i  (flush),
    .load_i  (head_load_s),
    .clear_i (head_clear_s),
    .d_i     (head_d_s),
    .valid_o (head_valid_s),
    .q_o     (head_pl_s)
  );

  skid_slot #(.PW(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .zero_i  (flush),
    .load_i  (skid_load_s),
    .clear_i (skid_clear_s),
    .d_i     (in_pl_s),
    .valid_o (skid_valid_s),
    .q_o     (skid_pl_s)
  );

  // Halt latch and retire counter next state; flush never counts as a retire.
  always_comb begin
    halted_d = halted_q;
    count_d  = count_q;
    if (retire_s) begin
      halted_d = halted_q | head_pl_s[TERM_B];
      count_d  = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      halted_d = halted_q;
      count_d  = count_q;
    end
  end

  // Halt and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
      count_q  <= {CNT_W{1'b0}};
    end else begin
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign mem_res_s     = head_pl_s[MEM_LO +: WORD];
  assign alu_res_s     = head_pl_s[ALU_LO +: WORD];

  assign out_valid     = head_valid_s;
  assign wb_out        = head_pl_s[WB_B];
  assign mem_r_out     = head_pl_s[MEMR_B];
  assign terminate_out = head_pl_s[TERM_B];
  assign reg_dest_out  = head_pl_s[DEST_LO +: RAW];
  assign wb_data_out   = head_pl_s[MEMR_B] ? mem_res_s : alu_res_s;

  // Forwarding comes from the head only; r0 is never a forwarding target.
  assign fwd_valid     = head_valid_s && head_pl_s[WB_B] &&
                         (head_pl_s[DEST_LO +: RAW] != {RAW{1'b0}});
  assign fwd_dest      = head_pl_s[DEST_LO +: RAW];
  assign fwd_data      = wb_data_out;

  assign halted        = halted_q;
  assign retired_count = count_q;

endmodule
